// File: rtl/avg_pkg.sv
// Shared defaults for the averaging pipeline (sliding_window, avg_decimate_fifo, benches)
// plus an elaboration-time log2 helper for pointer and level widths.
package avg_pkg;

  localparam int unsigned AVG_WIDTH = 32;
  localparam int unsigned AVG_DEC   = 4;
  localparam int unsigned AVG_DEPTH = 16;
  localparam int unsigned AVG_CNT_W = 16;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/avg_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter and registered
// head-of-queue data, valid and full flags.
module avg_sync_fifo
  import avg_pkg::*;
#(
  parameter int unsigned WIDTH = AVG_WIDTH,
  parameter int unsigned DEPTH = AVG_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [clog2(DEPTH):0]  level,
  output logic                   not_empty,
  output logic                   full
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop     = pop && not_empty && !flush;
    do_push    = push && !flush && (!full || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt  = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Head register: a write landing on the next read slot means the FIFO holds only that word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      not_empty <= 1'b0;
      full      <= 1'b0;
      rd_data   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      not_empty <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      not_empty <= (level_nxt != '0);
      full      <= (level_nxt == LVL_W'(DEPTH));
      rd_data   <= (do_push && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/avg_decimate_fifo.sv
// Keeps every DEC-th average and buffers it for a slow ready/valid consumer; overflow is
// flagged, never stalled. AVG_DECIMATE_FIFO_DROP_CNT_EN adds a saturating drop counter.
module avg_decimate_fifo
  import avg_pkg::*;
#(
  parameter int unsigned WIDTH = AVG_WIDTH,
  parameter int unsigned DEC   = AVG_DEC,
  parameter int unsigned DEPTH = AVG_DEPTH
`ifdef AVG_DECIMATE_FIFO_DROP_CNT_EN
  ,
  parameter int unsigned CNT_W = AVG_CNT_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_sample,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow
`ifdef AVG_DECIMATE_FIFO_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]      drop_cnt
`endif
);

  localparam int unsigned PH_W = (DEC > 1) ? clog2(DEC) : 1;

  logic [PH_W-1:0] phase;
  logic            full;
  logic            keep_c;
  logic            pop_c;
  logic            push_c;
  logic            drop_c;

  // Flush discards a coincident sample, so it never reaches the FIFO or the overflow flag.
  always_comb begin
    keep_c = in_valid && (phase == '0) && !flush;
    pop_c  = out_valid && out_ready && !flush;
    push_c = keep_c && (!full || pop_c);
    drop_c = keep_c && full && !pop_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (flush) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PH_W'(DEC - 1)) ? '0 : phase + PH_W'(1);
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef AVG_DECIMATE_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      drop_cnt <= drop_c ? CNT_W'(1) : '0;
    end else if (drop_c && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

  avg_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .pop       (pop_c),
    .flush     (flush),
    .wr_data   (in_sample),
    .rd_data   (out_data),
    .level     (level),
    .not_empty (out_valid),
    .full      (full)
  );

endmodule

// File: doc/avg_decimate_fifo.md
Name: avg_decimate_fifo

Overview:
- Downstream stage of sliding_window: consumes its out_valid/out_avg stream.
- Keeps every DEC-th average and drops the rest.
- Buffers kept samples in a DEPTH-entry synchronous FIFO and presents them on a ready/valid interface to a slower consumer (logger/UART/bus bridge).
- Input side has no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
- WIDTH, 32: sample width, signed two's complement; matches sliding_window WIDTH.
- DEC, 4: decimation factor, >=1; DEC=1 keeps every sample.
- DEPTH, 16: FIFO entries; power of two, >=2.
- CNT_W, 16: drop counter width (optional feature only).

Ports:
- clk, input, 1: single clock, all logic on rising edge.
- rst, input, 1: reset, asynchronous, active-low (asserted when 0).
- in_valid, input, 1: one-cycle strobe, new average present; connects to sliding_window out_valid.
- in_sample, input, WIDTH: signed average; connects to out_avg.
- flush, input, 1: synchronous flush of FIFO and decimation phase.
- clr_ovf, input, 1: synchronous clear of overflow (and drop_cnt).
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, WIDTH: head-of-FIFO sample, first-word-fall-through.
- level, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky, a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): phase=0, rd_ptr=wr_ptr=0, level=0, out_valid=0, overflow=0, drop_cnt=0. out_data is don't-care while out_valid=0. Deassertion takes effect at the next rising edge.
- Decimation phase counter (0..DEC-1):
  - Advances by 1 on each in_valid, wrapping DEC-1 -> 0.
  - Sample is kept when in_valid=1 and phase==0, i.e. input indices 0, DEC, 2*DEC, ...
  - With DEC=1 every sample is kept.
- push = kept and (level<DEPTH or pop).
- pop = out_valid and out_ready.
- Simultaneous push+pop: allowed at any level, including full (entry freed same edge); level unchanged.
- Full, kept, no pop: sample discarded; overflow<=1 at that edge; FIFO contents unchanged.
- Latency: kept sample accepted at edge k is visible on out_data/out_valid after edge k (1 cycle). Empty-FIFO bypass is not implemented.
- out_data = mem[rd_ptr] (FWFT); stays stable while out_valid=1 and out_ready=0.
- Pointers: $clog2(DEPTH) bits, natural wrap. level is a separate counter, +1 on push only, -1 on pop only.
- flush=1:
  - Next edge sets rd_ptr=wr_ptr=0, level=0, phase=0.
  - Overrides push/pop in the same cycle; an in_valid coincident with flush is discarded and does not set overflow.
  - overflow is untouched.
- clr_ovf=1: overflow<=0 next edge. If a drop occurs the same cycle, the set wins (overflow=1).
- No arithmetic on samples; data passes bit-exact, sign preserved.
- Reset mid-stream: all state lost immediately; the first in_valid after reset is index 0 (kept).

Optional Feature:
- Macro AVG_DECIMATE_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt [CNT_W-1:0], counting discarded kept samples.
  - Saturates at all-ones.
  - Cleared by reset and by clr_ovf; on a clr_ovf+drop collision it loads 1.
- Undefined: port and counter absent; overflow flag only.

Decomposition:
- Package avg_pkg: default WIDTH/DEC/DEPTH constants shared with sliding_window and benches; function clog2 for pointer/level widths.
- One sub-module, avg_sync_fifo (WIDTH, DEPTH): storage, pointers, level, FWFT read, full/empty.
- Top keeps the phase counter, keep/drop decision, overflow and drop counter.

Test Plan:
- DEC=4, DEPTH=16, out_ready=1, inputs 0..15 one per 2 clocks -> out_data sequence 0, 4, 8, 12, each valid one cycle after its push edge; overflow=0.
- DEC=1, out_ready=0, 20 samples 100..119 -> level=16, out_valid=1, out_data=100, overflow=1, drop_cnt=4 (macro on). Then out_ready=1 drains 100..115 in order, level reaches 0.
- Full FIFO (16 entries), kept push and pop on the same edge -> level stays 16, no overflow, new sample lands at tail.
- Negative values -2147483648, -1 with DEC=1 -> out_data bit-exact 32'h80000000, 32'hFFFFFFFF.
- flush mid-stream (level=5, phase=2) with coincident in_valid -> next cycle level=0, out_valid=0, overflow unchanged; the following in_valid is kept.
- Async reset asserted between clock edges with level=7 -> out_valid=0 and level=0 immediately without a clock edge; after release the first sample is kept.
